// File: rtl/ro_puf_if.sv
// Request/result bundle between the key-generation FSM (master) and the
// RO PUF measurement sequencer (slave).
interface ro_puf_if #(
  parameter int SEL_W = 3,
  parameter int WIN_W = 16,
  parameter int CNT_W = 16
) ();
  logic             start;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic [WIN_W-1:0] window_len;
  logic             busy;
  logic             done;
  logic             response;
  logic             tie;
  logic             err;
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_b;

  modport master (
    output start, sel_a, sel_b, window_len,
    input  busy, done, response, tie, err, count_a, count_b
  );

  modport slave (
    input  start, sel_a, sel_b, window_len,
    output busy, done, response, tie, err, count_a, count_b
  );
endinterface

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF measurement sequencer: enable two ROs, count edges over a
// window, report count_a > count_b. Define RO_PUF_MAJ_EN for 3-round majority vote.
module ro_puf_edge (
  input  logic clk,
  input  logic rst,
  input  logic ro_i,
  output logic rise_o
);
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], ro_i};
  end

  // sync_q[1:0] is the 2-FF synchronizer; sync_q[2] is the edge-detect history
  assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

module ro_puf_ctrl #(
  parameter int NUM_RO     = 8,
  parameter int SEL_W      = 3,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_RO-1:0] ro_out,
  output logic [NUM_RO-1:0] ro_en,
  ro_puf_if.slave           bus
);
`ifdef RO_PUF_MAJ_EN
  localparam int ROUNDS = 3;
`else
  localparam int ROUNDS = 1;
`endif
  localparam logic [WIN_W-1:0] SETTLE_LD = WIN_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, COUNT, FLUSH, DONE} state_e;

  state_e            state_q;
  logic [NUM_RO-1:0] rise;
  logic [SEL_W-1:0]  sel_a_q, sel_b_q;
  logic [NUM_RO-1:0] en_mask_q, ro_en_q;
  logic [WIN_W-1:0]  win_q, tmr_q;
  logic [CNT_W-1:0]  cnt_a_q, cnt_b_q, cnt_a_d, cnt_b_d;
  logic [CNT_W-1:0]  out_a_q, out_b_q;
  logic [1:0]        round_q, votes_q, votes_d;
  logic              tie_all_q, tie_all_d;
  logic              busy_q, done_q, resp_q, tie_q, err_q;
  logic              illegal;

  ro_puf_edge u_edge [NUM_RO-1:0] (
    .clk    (clk),
    .rst    (rst),
    .ro_i   (ro_out),
    .rise_o (rise)
  );

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (rise[sel_a_q] && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + CNT_W'(1);
    if (rise[sel_b_q] && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + CNT_W'(1);
    votes_d   = votes_q + {1'b0, (cnt_a_q > cnt_b_q)};
    tie_all_d = tie_all_q & (cnt_a_q == cnt_b_q);
    illegal   = (bus.sel_a == bus.sel_b) || (bus.window_len == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      en_mask_q <= '0;
      ro_en_q   <= '0;
      win_q     <= '0;
      tmr_q     <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      out_a_q   <= '0;
      out_b_q   <= '0;
      round_q   <= '0;
      votes_q   <= '0;
      tie_all_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      resp_q    <= 1'b0;
      tie_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          sel_a_q   <= bus.sel_a;
          sel_b_q   <= bus.sel_b;
          win_q     <= bus.window_len;
          en_mask_q <= (NUM_RO'(1) << bus.sel_a) | (NUM_RO'(1) << bus.sel_b);
          cnt_a_q   <= '0;
          cnt_b_q   <= '0;
          round_q   <= '0;
          votes_q   <= '0;
          tie_all_q <= 1'b1;
          busy_q    <= 1'b1;
          if (illegal) begin
            // reject without ever powering an oscillator
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            resp_q  <= 1'b0;
            tie_q   <= 1'b0;
            out_a_q <= '0;
            out_b_q <= '0;
          end else begin
            state_q <= SETTLE;
            tmr_q   <= SETTLE_LD;
            ro_en_q <= (NUM_RO'(1) << bus.sel_a) | (NUM_RO'(1) << bus.sel_b);
          end
        end
        SETTLE: begin
          if (tmr_q == '0) begin
            state_q <= COUNT;
            tmr_q   <= win_q - WIN_W'(1);
          end else begin
            tmr_q <= tmr_q - WIN_W'(1);
          end
        end
        COUNT: begin
          cnt_a_q <= cnt_a_d;
          cnt_b_q <= cnt_b_d;
          if (tmr_q == '0) begin
            state_q <= FLUSH;
            ro_en_q <= '0;
            tmr_q   <= WIN_W'(1);
          end else begin
            tmr_q <= tmr_q - WIN_W'(1);
          end
        end
        FLUSH: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - WIN_W'(1);
          end else begin
            votes_q   <= votes_d;
            tie_all_q <= tie_all_d;
            if (round_q != 2'(ROUNDS - 1)) begin
              round_q <= round_q + 2'd1;
              cnt_a_q <= '0;
              cnt_b_q <= '0;
              state_q <= SETTLE;
              tmr_q   <= SETTLE_LD;
              ro_en_q <= en_mask_q;
            end else begin
              // a tied round contributes no vote, so all-tied implies response=0
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
              resp_q  <= (votes_d > 2'(ROUNDS / 2));
              tie_q   <= tie_all_d;
              out_a_q <= cnt_a_q;
              out_b_q <= cnt_b_q;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // reset kills the oscillators in the same cycle it is raised
  assign ro_en        = ro_en_q & {NUM_RO{~rst}};
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.response = resp_q;
  assign bus.tie      = tie_q;
  assign bus.err      = err_q;
  assign bus.count_a  = out_a_q;
  assign bus.count_b  = out_b_q;
endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Bench for ro_puf_ctrl: free-running synthetic RO bank, request-level model,
// per-cycle compare against two instances (CNT_W=16 and CNT_W=4).
module tb_ro_puf_ctrl;
  localparam int S = 4;
`ifdef RO_PUF_MAJ_EN
  localparam int ROUNDS = 3;
`else
  localparam int ROUNDS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ro = '0;
  logic [7:0] ro_en0, ro_en1;
  int         cyc = 0;
  int         npass = 0, ntot = 0;
  bit         chk_on = 1'b0;

  // RO periods in clk cycles (0 = stuck low); all used windows are multiples
  int per [8] = '{0, 8, 4, 4, 2, 6, 4, 12};
  int maxc [2] = '{65535, 15};

  bit         act [2];
  int         acc [2], lat [2], win [2];
  bit         ill [2];
  logic [7:0] mask [2];
  bit         e_resp [2], e_tie [2], e_err [2];
  int         e_ca [2], e_cb [2];

  ro_puf_if #(.SEL_W(3), .WIN_W(16), .CNT_W(16)) b0 ();
  ro_puf_if #(.SEL_W(3), .WIN_W(16), .CNT_W(4))  b1 ();

  ro_puf_ctrl #(.NUM_RO(8), .SEL_W(3), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(S)) u0 (
    .clk(clk), .rst(rst), .ro_out(ro), .ro_en(ro_en0), .bus(b0));
  ro_puf_ctrl #(.NUM_RO(8), .SEL_W(3), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(S)) u1 (
    .clk(clk), .rst(rst), .ro_out(ro), .ro_en(ro_en1), .bus(b1));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 8; i++)
      ro[i] = (per[i] != 0) && ((cyc % per[i]) < (per[i] / 2));
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
  endtask

  function automatic bit idle(input int d);
    return !act[d] || ((cyc - acc[d]) > lat[d]);
  endfunction

  function automatic int edges(input int w, input int p, input int mx);
    int v;
    v = (p > 0) ? w / p : 0;
    return (v > mx) ? mx : v;
  endfunction

  task automatic drive(input int d, input bit s, input int a, input int b, input int w);
    if (d == 0) begin
      b0.start = s; b0.sel_a = 3'(a); b0.sel_b = 3'(b); b0.window_len = 16'(w);
    end else begin
      b1.start = s; b1.sel_a = 3'(a); b1.sel_b = 3'(b); b1.window_len = 16'(w);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      act[d] = 0; acc[d] = 0; lat[d] = 0; win[d] = 0; ill[d] = 0; mask[d] = '0;
      e_resp[d] = 0; e_tie[d] = 0; e_err[d] = 0; e_ca[d] = 0; e_cb[d] = 0;
    end
  endtask

  // Issue a request once the model says the DUT is idle; record what it must return.
  task automatic req(input int d, input int a, input int b, input int w);
    @(posedge clk); #2;
    for (int i = 0; i < 5000 && !idle(d); i++) begin @(posedge clk); #2; end
    drive(d, 1, a, b, w);
    @(posedge clk); #2;
    drive(d, 0, a, b, w);
    act[d]  = 1;
    acc[d]  = cyc;
    win[d]  = w;
    ill[d]  = (a == b) || (w == 0);
    mask[d] = 8'(1 << a) | 8'(1 << b);
    if (ill[d]) begin
      lat[d] = 0; e_err[d] = 1; e_resp[d] = 0; e_tie[d] = 0; e_ca[d] = 0; e_cb[d] = 0;
    end else begin
      lat[d]    = ROUNDS * (S + w + 2);
      e_ca[d]   = edges(w, per[a], maxc[d]);
      e_cb[d]   = edges(w, per[b], maxc[d]);
      e_resp[d] = e_ca[d] > e_cb[d];
      e_tie[d]  = e_ca[d] == e_cb[d];
      e_err[d]  = 0;
    end
  endtask

  task automatic wait_done(input int d, output int k);
    k = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((d == 0) ? b0.done : b1.done) begin k = cyc - acc[d]; break; end
    end
    if (k < 0) chk("done_timeout", 32'(0), 32'(1));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        int k;
        bit run, dn_e;
        logic [7:0] en_e, ren;
        logic [15:0] ca, cb;
        logic bsy, dn, rs, te, er;
        k    = cyc - acc[d];
        run  = act[d] && (k <= lat[d]);
        dn_e = act[d] && (k == lat[d]);
        en_e = '0;
        if (act[d] && !ill[d] && (k < lat[d]) && ((k % (S + win[d] + 2)) < (S + win[d])))
          en_e = mask[d];
        if (d == 0) begin
          bsy = b0.busy; dn = b0.done; rs = b0.response; te = b0.tie; er = b0.err;
          ca = b0.count_a; cb = b0.count_b; ren = ro_en0;
        end else begin
          bsy = b1.busy; dn = b1.done; rs = b1.response; te = b1.tie; er = b1.err;
          ca = {12'b0, b1.count_a}; cb = {12'b0, b1.count_b}; ren = ro_en1;
        end
        chk($sformatf("busy%0d", d), 32'(bsy), 32'(run));
        chk($sformatf("done%0d", d), 32'(dn), 32'(dn_e));
        chk($sformatf("ro_en%0d", d), 32'(ren), 32'(en_e));
        if (!act[d] || (k >= lat[d])) begin
          chk($sformatf("response%0d", d), 32'(rs), 32'(e_resp[d]));
          chk($sformatf("tie%0d", d), 32'(te), 32'(e_tie[d]));
          chk($sformatf("err%0d", d), 32'(er), 32'(e_err[d]));
          chk($sformatf("count_a%0d", d), 32'(ca), 32'(e_ca[d]));
          chk($sformatf("count_b%0d", d), 32'(cb), 32'(e_cb[d]));
        end
      end
    end
  end

  initial begin
    int k;
    clear_model();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ro_en", 32'(ro_en0), 32'(0));
    chk("rst_busy", 32'(b0.busy), 32'(0));
    chk("rst_done", 32'(b0.done), 32'(0));
    chk("rst_count_a", 32'(b0.count_a), 32'(0));
    @(posedge clk); #2;
    rst = 0;
    chk_on = 1;

    // A faster than B
    req(0, 3, 5, 96);
    wait_done(0, k);
    chk("lat_legal", 32'(k), 32'((ROUNDS == 1) ? 102 : 306));
    chk("t1_count_a", 32'(b0.count_a), 32'(24));
    chk("t1_count_b", 32'(b0.count_b), 32'(16));
    chk("t1_response", 32'(b0.response), 32'(1));

    // swapped
    req(0, 5, 3, 96);
    wait_done(0, k);
    chk("t2_response", 32'(b0.response), 32'(0));
    chk("t2_tie", 32'(b0.tie), 32'(0));

    // equal periods
    req(0, 3, 6, 96);
    wait_done(0, k);
    chk("t3_tie", 32'(b0.tie), 32'(1));
    chk("t3_response", 32'(b0.response), 32'(0));

    // illegal: same oscillator, then zero window
    req(0, 2, 2, 96);
    wait_done(0, k);
    chk("lat_illegal_sel", 32'(k), 32'(0));
    chk("t4_err", 32'(b0.err), 32'(1));
    req(0, 1, 3, 0);
    wait_done(0, k);
    chk("lat_illegal_win", 32'(k), 32'(0));
    chk("t5_err", 32'(b0.err), 32'(1));

    // 4-bit counters: period-2 RO gives 32 edges, must clamp at 15
    req(1, 4, 1, 64);
    wait_done(1, k);
    chk("sat_count_a", 32'(b1.count_a), 32'(15));
    chk("sat_count_b", 32'(b1.count_b), 32'(8));
    chk("sat_response", 32'(b1.response), 32'(1));

    // start (with different operands) pulsed mid-COUNT is ignored
    req(0, 7, 1, 48);
    repeat (20) @(posedge clk);
    #2;
    drive(0, 1, 3, 5, 96);
    @(posedge clk); #2;
    drive(0, 0, 3, 5, 96);
    wait_done(0, k);
    chk("lat_ignored_start", 32'(k), 32'(ROUNDS * 54));
    chk("t7_count_a", 32'(b0.count_a), 32'(4));
    chk("t7_count_b", 32'(b0.count_b), 32'(6));

    // reset during COUNT: enables drop immediately, no done afterwards
    req(0, 3, 5, 96);
    repeat (40) @(posedge clk);
    #2;
    rst = 1;
    chk_on = 0;
    clear_model();
    @(negedge clk);
    chk("rst_mid_ro_en", 32'(ro_en0), 32'(0));
    @(posedge clk); #2;
    rst = 0;
    chk_on = 1;
    repeat (150) @(negedge clk);
    chk("post_rst_count_a", 32'(b0.count_a), 32'(0));

    // recovery after abort
    req(0, 5, 7, 96);
    wait_done(0, k);
    chk("t9_count_a", 32'(b0.count_a), 32'(16));
    chk("t9_count_b", 32'(b0.count_b), 32'(8));
    chk("t9_response", 32'(b0.response), 32'(1));
    repeat (3) @(negedge clk);

    chk_on = 0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
